// File: rtl/uart_rx_if.sv
// uart_rx output bundle: received-byte stream plus fault pulses.
// master = receiver side, slave = downstream consumer.
interface uart_rx_if;
  logic [7:0] m_axis_tdata_o;
  logic       m_axis_tvalid_o;
  logic       m_axis_tready_i;
  logic       frame_err_o;
  logic       overrun_o;
  logic       parity_err_o;

  modport master (
    output m_axis_tdata_o,
    output m_axis_tvalid_o,
    input  m_axis_tready_i,
    output frame_err_o,
    output overrun_o,
    output parity_err_o
  );

  modport slave (
    input  m_axis_tdata_o,
    input  m_axis_tvalid_o,
    output m_axis_tready_i,
    input  frame_err_o,
    input  overrun_o,
    input  parity_err_o
  );
endinterface

// File: rtl/uart_rx.sv
// uart_rx: oversampling 8N1 deframer with a one-entry stream output.
// Define UART_RX_PARITY_EN for 8E1 frames with parity checking.
module uart_rx #(
  parameter int CLK_FREQ = 160_000_000,
  parameter int BAUD     = 115200
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       rx_i,
  uart_rx_if.master  m_axis
);

  localparam int CPB  = CLK_FREQ / BAUD;
  localparam int HALF = CPB / 2;
  localparam int CW   = (CPB > 1) ? $clog2(CPB) : 1;

  if (CPB < 4) begin : g_cpb_chk
    $error("uart_rx: CLK_FREQ/BAUD must be at least 4");
  end

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {
    HUNT, IDLE, START, DATA, PARITY, STOP
  } state_t;
`else
  typedef enum logic [2:0] {
    HUNT, IDLE, START, DATA, STOP
  } state_t;
`endif

  state_t     state_q, state_d;
  logic       sync1_q, sync1_d;
  logic       rx_s_q, rx_s_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0] bitidx_q, bitidx_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] tdata_q, tdata_d;
  logic       tvalid_q, tvalid_d;
  logic       frame_err_q, frame_err_d;
  logic       overrun_q, overrun_d;
`ifdef UART_RX_PARITY_EN
  logic       par_q, par_d;
  logic       parity_err_q, parity_err_d;
`endif

  logic tick;
  logic half_tick;
  logic par_ok;
  logic deliver;
  logic tready;

  assign tready    = m_axis.m_axis_tready_i;
  assign tick      = (cnt_q == CW'(CPB - 1));
  assign half_tick = (cnt_q == CW'(HALF - 1));

  // next-state: synchronizer, bit timing, deframing, delivery
  always_comb begin
    sync1_d     = rx_i;
    rx_s_d      = sync1_q;
    state_d     = state_q;
    cnt_d       = tick ? '0 : cnt_q + 1'b1;
    bitidx_d    = bitidx_q;
    shift_d     = shift_q;
    tdata_d     = tdata_q;
    tvalid_d    = tvalid_q & ~tready;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;
    deliver     = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_d        = par_q;
    parity_err_d = 1'b0;
    par_ok       = ((^shift_q) == par_q);
`else
    par_ok       = 1'b1;
`endif

    unique case (state_q)
      HUNT: begin
        if (rx_s_q) state_d = IDLE;
      end
      IDLE: begin
        if (!rx_s_q) begin
          cnt_d   = '0;
          state_d = START;
        end
      end
      START: begin
        if (half_tick) begin
          if (!rx_s_q) begin
            state_d  = DATA;
            cnt_d    = '0;
            bitidx_d = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      DATA: begin
        if (tick) begin
          shift_d  = {rx_s_q, shift_q[7:1]};
          bitidx_d = bitidx_q + 3'd1;
          if (bitidx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (tick) begin
          par_d   = rx_s_q;
          state_d = STOP;
        end
      end
`endif
      STOP: begin
        if (tick) begin
          if (!rx_s_q) begin
            frame_err_d = 1'b1;
            state_d     = HUNT;
          end else if (!par_ok) begin
`ifdef UART_RX_PARITY_EN
            parity_err_d = 1'b1;
`endif
            state_d = IDLE;
          end else begin
            deliver = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = HUNT;
    endcase

    if (deliver) begin
      if (!tvalid_q || tready) begin
        tdata_d  = shift_q;
        tvalid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  // state and output registers, synchronous reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q     <= 1'b1;
      rx_s_q      <= 1'b1;
      state_q     <= HUNT;
      cnt_q       <= '0;
      bitidx_q    <= '0;
      shift_q     <= '0;
      tdata_q     <= '0;
      tvalid_q    <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q        <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      sync1_q     <= sync1_d;
      rx_s_q      <= rx_s_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bitidx_q    <= bitidx_d;
      shift_q     <= shift_d;
      tdata_q     <= tdata_d;
      tvalid_q    <= tvalid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
`ifdef UART_RX_PARITY_EN
      par_q        <= par_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  assign m_axis.m_axis_tdata_o  = tdata_q;
  assign m_axis.m_axis_tvalid_o = tvalid_q;
  assign m_axis.frame_err_o     = frame_err_q;
  assign m_axis.overrun_o       = overrun_q;
`ifdef UART_RX_PARITY_EN
  assign m_axis.parity_err_o    = parity_err_q;
`else
  assign m_axis.parity_err_o    = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed frames, scoreboard queue of expected bytes,
// monitor process pops on every stream transfer.
module tb_uart_rx;

  localparam int CF  = 1600;
  localparam int BD  = 100;
  localparam int CPB = 16;
`ifdef UART_RX_PARITY_EN
  localparam int LAT = 171;
`else
  localparam int LAT = 155;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx  = 1'b1;
  int   cyc = 0;

  uart_rx_if bus ();

  uart_rx #(
    .CLK_FREQ(CF),
    .BAUD    (BD)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .rx_i  (rx),
    .m_axis(bus.master)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] data;
    int         at;
  } exp_t;

  exp_t q[$];
  int vectors = 0;
  int miscompares = 0;
  int n_xfer = 0;
  int n_vhigh = 0;
  int n_ferr = 0;
  int n_ovr = 0;
  int n_perr = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic idle(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bit_out(logic b);
    rx = b;
    idle(CPB);
  endtask

  task automatic send(logic [7:0] d, logic stop, logic par);
    bit_out(1'b0);
    for (int i = 0; i < 8; i++) bit_out(d[i]);
`ifdef UART_RX_PARITY_EN
    bit_out(par);
`else
    if (par === 1'bx) rx = 1'b1;
`endif
    bit_out(stop);
    rx = 1'b1;
  endtask

  task automatic expect_byte(logic [7:0] d, int at);
    exp_t e;
    e.data = d;
    e.at   = at;
    q.push_back(e);
  endtask

  int x0, v0, f0, o0, p0;

  task automatic snap();
    x0 = n_xfer;
    v0 = n_vhigh;
    f0 = n_ferr;
    o0 = n_ovr;
    p0 = n_perr;
  endtask

  initial begin
    bus.m_axis_tready_i = 1'b1;

    fork
      forever begin
        @(negedge clk);
        if (!rst) begin
          if (bus.m_axis_tvalid_o) n_vhigh++;
          if (bus.frame_err_o) n_ferr++;
          if (bus.overrun_o) n_ovr++;
          if (bus.parity_err_o) n_perr++;
          if (bus.m_axis_tvalid_o && bus.m_axis_tready_i) begin
            exp_t e;
            n_xfer++;
            if (q.size() == 0) begin
              vectors++;
              miscompares++;
              $display("FAIL unexpected_xfer: got %0h, expected none",
                       bus.m_axis_tdata_o);
            end else begin
              e = q.pop_front();
              check("tdata", bus.m_axis_tdata_o, e.data);
              if (e.at >= 0) check("latency", cyc, e.at);
            end
          end
        end
      end
    join_none

    // reset state
    idle(4);
    check("rst_tvalid", bus.m_axis_tvalid_o, 0);
    check("rst_tdata", bus.m_axis_tdata_o, 0);
    check("rst_ferr", bus.frame_err_o, 0);
    check("rst_ovr", bus.overrun_o, 0);
    check("rst_perr", bus.parity_err_o, 0);
    rst = 1'b0;
    idle(2 * CPB);

    // 1: basic receive, exact latency and one-cycle valid
    snap();
    expect_byte(8'hA5, cyc + LAT);
    send(8'hA5, 1'b1, ^8'hA5);
    idle(4);
    check("t1_vhigh", n_vhigh - v0, 1);
    check("t1_xfer", n_xfer - x0, 1);
    check("t1_flags", (n_ferr - f0) + (n_ovr - o0) + (n_perr - p0), 0);

    // 2: back-to-back frames with downstream stalled
    bus.m_axis_tready_i = 1'b0;
    snap();
    expect_byte(8'h3C, -1);
    send(8'h3C, 1'b1, ^8'h3C);
    send(8'h81, 1'b1, ^8'h81);
    idle(2);
    check("t2_ovr", n_ovr - o0, 1);
    check("t2_tdata_held", bus.m_axis_tdata_o, 8'h3C);
    check("t2_tvalid_held", bus.m_axis_tvalid_o, 1);
    check("t2_no_xfer", n_xfer - x0, 0);
    bus.m_axis_tready_i = 1'b1;
    idle(4);
    check("t2_xfer", n_xfer - x0, 1);
    check("t2_tvalid_clr", bus.m_axis_tvalid_o, 0);

    // 3: framing error then a long break
    snap();
    send(8'h55, 1'b0, ^8'h55);
    rx = 1'b0;
    idle(40 * CPB);
    check("t3_ferr", n_ferr - f0, 1);
    check("t3_no_xfer", n_xfer - x0, 0);
    rx = 1'b1;
    idle(2 * CPB);
    expect_byte(8'h12, -1);
    send(8'h12, 1'b1, ^8'h12);
    idle(4);
    check("t3_ferr_once", n_ferr - f0, 1);
    check("t3_xfer", n_xfer - x0, 1);

    // 4: short low glitch is ignored
    snap();
    rx = 1'b0;
    idle(3);
    rx = 1'b1;
    idle(3 * CPB);
    check("t4_no_valid", n_vhigh - v0, 0);
    check("t4_flags", (n_ferr - f0) + (n_ovr - o0) + (n_perr - p0), 0);
    expect_byte(8'h5A, -1);
    send(8'h5A, 1'b1, ^8'h5A);
    idle(4);
    check("t4_xfer", n_xfer - x0, 1);

    // 5: reset mid-frame clears a held byte and the partial frame
    bus.m_axis_tready_i = 1'b0;
    snap();
    send(8'h6B, 1'b1, ^8'h6B);
    idle(2);
    check("t5_held", bus.m_axis_tdata_o, 8'h6B);
    bit_out(1'b0);
    bit_out(1'b0);
    bit_out(1'b0);
    rst = 1'b1;
    idle(1);
    check("t5_rst_tvalid", bus.m_axis_tvalid_o, 0);
    check("t5_rst_tdata", bus.m_axis_tdata_o, 0);
    check("t5_rst_flags",
          {bus.frame_err_o, bus.overrun_o, bus.parity_err_o}, 0);
    rst = 1'b0;
    rx = 1'b1;
    bus.m_axis_tready_i = 1'b1;
    idle(2 * CPB);
    check("t5_no_xfer", n_xfer - x0, 0);
    expect_byte(8'hF0, -1);
    send(8'hF0, 1'b1, ^8'hF0);
    idle(4);
    check("t5_xfer", n_xfer - x0, 1);
    check("t5_flags", (n_ferr - f0) + (n_ovr - o0) + (n_perr - p0), 0);

`ifdef UART_RX_PARITY_EN
    // 6: even parity good and bad
    snap();
    expect_byte(8'h07, cyc + LAT);
    send(8'h07, 1'b1, 1'b1);
    idle(4);
    check("t6_good_perr", n_perr - p0, 0);
    check("t6_good_xfer", n_xfer - x0, 1);
    send(8'h07, 1'b1, 1'b0);
    idle(4);
    check("t6_bad_perr", n_perr - p0, 1);
    check("t6_bad_xfer", n_xfer - x0, 1);
`endif

    check("queue_drained", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
